overflow_event_logger: RTL
==========================

# overflow_event_logger

Downstream stage of `counter8_overflow`. It watches that counter's `overflow` output, turns each rising edge into one event, and timestamps the event with a free-running cycle counter. Timestamps are buffered in a small show-ahead FIFO and read out over a valid/ready interface. Saturating event and drop counters are kept for software inspection.

## Interface
- `TS_W`, 8: timestamp width; the timestamp counter wraps modulo 2^TS_W.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `CNT_W`, 8: width of `event_count` and `drop_count`.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `overflow` input 1: from `counter8_overflow`; level signal, edge-detected here.
- `out_ready` input 1: consumer accepts the head entry.
- `out_valid` output 1: FIFO is non-empty.
- `out_data` output TS_W: head-entry timestamp; valid only while `out_valid`=1.
- `event_count` output CNT_W: rising edges seen; saturating.
- `drop_count` output CNT_W: events lost to a full FIFO; saturating.
- `full` output 1: occupancy == DEPTH.
- `empty` output 1: occupancy == 0.

## Operation
- Edge detect:
  - `ovf_d` registers `overflow`; `ovf_d` resets to 0.
  - `event` = `overflow & ~ovf_d`.
  - If `overflow` is already high in the first cycle after reset, that counts as an event.
- Timestamp:
  - `ts` resets to 0 and increments every cycle.
  - It wraps from 2^TS_W−1 to 0 with no flag.
  - An event captures `ts` as it stands in the event cycle, before the increment.
- Pop: `pop` = `out_valid & out_ready`.
- Push:
  - `push` = `event & (~full | pop)`.
  - When full, a simultaneous pop frees a slot and the event is accepted.
- Occupancy states:
  - States are EMPTY (0), PARTIAL (1..DEPTH−1) and FULL (DEPTH).
  - Push only: occupancy +1.
  - Pop only: occupancy −1.
  - Push and pop together: unchanged, with pointers both advancing.
  - Pop while EMPTY is impossible because `out_valid`=0.
- Drops:
  - `drop` = `event & full & ~pop`.
  - On a drop, `drop_count` increments and FIFO contents are untouched.
- `event_count` increments on every `event`, whether accepted or dropped.
- Saturation: both counters hold at 2^CNT_W−1 and never wrap.
- Ordering: strict FIFO; `out_data` is always the oldest unread timestamp.
- Reset mid-operation clears everything on the next edge:
  - pointers, occupancy, `ts`, `ovf_d` and both counters return to 0;
  - buffered entries are discarded, and `out_valid` is 0 from the following cycle.

## Timing
- Reset values: `out_valid`=0, `empty`=1, `full`=0, `event_count`=0, `drop_count`=0. `out_data` is don't-care.
- Latency: an event in cycle N makes `out_valid`=1 in cycle N+1, provided the FIFO was empty.
- `out_data` is a combinational read of the head: `mem[rd_ptr]`.
- All other outputs are registered or decode registered state only; there is no combinational path from `out_ready` to `out_valid`.
- Throughput: one push and one pop per cycle are sustained indefinitely.
- `event_count` and `drop_count` update in cycle N+1 for an event in cycle N.
- `full` and `empty` reflect occupancy after the previous edge.

## Structure
- Package `overflow_log_pkg` holds:
  - default constants `TS_W_DEF`, `DEPTH_DEF`, `CNT_W_DEF`;
  - a `sat_inc` function for the saturating counters.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) is the show-ahead FIFO:
  - ports: `clk`, `reset`, `push`, `din`, `pop`, `dout`, `full`, `empty`;
  - it uses pointers one bit wider than log2(DEPTH) to tell full from empty.
- The top level holds the edge detect, the timestamp counter, the drop/event counters and the push/pop gating.

## Test plan
- Reset, then pulse `overflow` high once in cycle 5 with `out_ready`=1 → `out_valid`=1 in cycle 6 with `out_data`=5; then `event_count`=1 and `drop_count`=0.
- Hold `overflow` high for 10 cycles → exactly one event is logged and `event_count`=1.
- `out_ready`=0, six single-cycle pulses → FIFO holds the first 4 timestamps, `full`=1, `drop_count`=2, `event_count`=6. Raising `out_ready` drains them in order and `empty`=1 afterwards.
- FIFO full, with an event and `out_ready`=1 in the same cycle → no drop; the new timestamp enters and occupancy stays at 4.
- Run 300 cycles with a pulse at `ts`=255 and another at `ts`=0 after the wrap → `out_data` reads 255 then 0.
- Apply `reset` while 3 entries are buffered → `out_valid`=0, both counters 0 and `ts` restarts at 0 on the next cycle.

Source files
------------

// File: rtl/overflow_event_logger_pkg.sv
// overflow_log_pkg
//   Shared constants, the FIFO occupancy state type and the saturating
//   increment helper used by the overflow event logger and its FIFO.
//   No ports (package).
package overflow_log_pkg;

  localparam int TS_W_DEF  = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Occupancy classes of the show-ahead FIFO.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Increment value, holding at the all-ones value of a width-bit counter.
  // Works on a 32-bit carrier so one function serves any width 1..32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = 32'hFFFF_FFFF >> (32 - width);
    if (value >= max_val) begin
      return max_val;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/overflow_event_logger_sync_fifo.sv
// sync_fifo
//   Show-ahead synchronous FIFO: dout always presents the oldest entry.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   Ports:
//     clk    - clock, rising edge
//     reset  - synchronous active-high reset (pointers and state only)
//     push   - write din this cycle (ignored when full unless popping too)
//     din    - data to write
//     pop    - consume the head entry (ignored when empty)
//     dout   - head entry, combinational read of mem[rd_ptr]
//     full   - occupancy == DEPTH (registered state)
//     empty  - occupancy == 0     (registered state)
module sync_fifo
  import overflow_log_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] occ_next;
  occ_state_t    state_reg;

  logic push_ok;
  logic pop_ok;

  // A pop from a full FIFO frees the slot the push lands in, so the push
  // is still legal in that case.
  assign pop_ok  = pop & (state_reg != OCC_EMPTY);
  assign push_ok = push & ((state_reg != OCC_FULL) | pop_ok);

  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};
  assign occ_next    = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      state_reg  <= OCC_EMPTY;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (occ_next == '0) begin
        state_reg <= OCC_EMPTY;
      end else if (occ_next == PW'(DEPTH)) begin
        state_reg <= OCC_FULL;
      end else begin
        state_reg <= OCC_PARTIAL;
      end
    end
  end

  // Storage needs no reset: nothing is visible until the pointers move.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  assign dout  = mem[rd_ptr_reg[AW-1:0]];
  assign full  = (state_reg == OCC_FULL);
  assign empty = (state_reg == OCC_EMPTY);

endmodule

// File: rtl/overflow_event_logger.sv
// overflow_event_logger
//   Turns each rising edge of a counter's overflow level into an event,
//   timestamps it with a free-running cycle counter and queues the stamp in
//   a show-ahead FIFO read over valid/ready. Keeps saturating counts of all
//   events and of events lost to a full FIFO.
//   Ports:
//     clk         - clock, rising edge
//     reset       - synchronous active-high reset
//     overflow    - overflow level from the upstream counter
//     out_ready   - consumer accepts the head entry
//     out_valid   - FIFO non-empty
//     out_data    - head timestamp (meaningful only while out_valid)
//     event_count - rising edges seen, saturating
//     drop_count  - events lost to a full FIFO, saturating
//     full        - FIFO occupancy == DEPTH
//     empty       - FIFO occupancy == 0
module overflow_event_logger
  import overflow_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             overflow,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [TS_W-1:0]  out_data,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             full,
  output logic             empty
);

  logic             ovf_d_reg;
  logic [TS_W-1:0]  ts_reg;
  logic [CNT_W-1:0] event_count_reg;
  logic [CNT_W-1:0] drop_count_reg;

  logic ovf_event;
  logic push;
  logic pop;
  logic drop;
  logic fifo_full;
  logic fifo_empty;

  // ovf_d_reg is 0 out of reset, so a level already high in the first
  // cycle after reset is seen as an edge.
  assign ovf_event = overflow & ~ovf_d_reg;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign push      = ovf_event & (~fifo_full | pop);
  assign drop      = ovf_event & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_d_reg       <= 1'b0;
      ts_reg          <= '0;
      event_count_reg <= '0;
      drop_count_reg  <= '0;
    end else begin
      ovf_d_reg <= overflow;
      // Wraps silently; the stamp pushed this cycle is the pre-increment value.
      ts_reg    <= ts_reg + 1'b1;
      if (ovf_event) begin
        event_count_reg <= CNT_W'(sat_inc(32'(event_count_reg), CNT_W));
      end
      if (drop) begin
        drop_count_reg <= CNT_W'(sat_inc(32'(drop_count_reg), CNT_W));
      end
    end
  end

  sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ts_reg),
    .pop   (pop),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign event_count = event_count_reg;
  assign drop_count  = drop_count_reg;
  assign full        = fifo_full;
  assign empty       = fifo_empty;

endmodule
